placement_sequencer: RTL and testbench
======================================

# placement_sequencer

Single-clock controller that sequences the rectangle-placement datapath with one-cycle stage enables instead of divided phase clocks. It clears the strip-occupancy array at start-up, then runs a fixed 4-phase round per rectangle: sample, read, write, output. It gates the array write on the strike result, counts placements and strikes, and stops the datapath when a strike limit is reached. It sits beside the datapath and drives its register enables and array control.

## Interface
- NUM_STRIPS, 13: number of occupancy-array entries cleared during INIT (addresses 0..NUM_STRIPS-1, max 16)
- STRIKE_MAX, 15: strike count at which the sequencer halts (1..15)
- clk_i  in  1  single system clock; all logic on rising edge
- rst_i  in  1  asynchronous, active-low reset
- start_i  in  1  pulse or level; in IDLE starts INIT
- stop_i  in  1  request to halt after the current round
- in_valid_i  in  1  rectangle present on width/height inputs; sampled in phase 0
- strike_flag_i  in  1  strike result from the detector; valid in phase 2
- sample_en_o  out  1  input-register enable
- rd_en_o  out  1  occupancy-array read enable
- wr_en_o  out  1  occupancy-array write enable (INIT clear or placement)
- clr_o  out  1  high in INIT; datapath muxes write data to 0 and address to clr_addr_o
- clr_addr_o  out  4  clear address
- out_en_o  out  1  output-register enable
- out_valid_o  out  1  output registers hold a valid result
- busy_o  out  1  state != IDLE
- halted_o  out  1  strike limit reached; sticky until reset or next start_i
- placed_cnt_o  out  8  successful placements, saturating at 255
- strike_cnt_o  out  4  strikes, saturating at STRIKE_MAX

## Operation
- FSM states: IDLE, INIT, RUN, DRAIN.
- IDLE: all enables 0. start_i=1 goes to INIT, clears the counters and halted_o, and sets clr_addr_o=0.
- INIT: each cycle wr_en_o=1, clr_o=1, clr_addr_o increments. The last write is at NUM_STRIPS-1; the next state is RUN with phase=0. INIT ignores stop_i and start_i.
- RUN: a 2-bit phase counter advances every cycle (0→1→2→3→0).
  - Phase 0: sample_en_o=1. Latch item_v = in_valid_i.
  - Phase 1: rd_en_o = item_v.
  - Phase 2: wr_en_o = item_v & ~strike_flag_i.
    - If item_v & ~strike_flag_i: placed_cnt increments.
    - If item_v & strike_flag_i: strike_cnt increments.
  - Phase 3: out_en_o = item_v.
- stop_i, or strike_cnt reaching STRIKE_MAX, is latched in any phase of RUN. The FSM moves to DRAIN and completes the current round through phase 3, then returns to IDLE.
- Reaching STRIKE_MAX sets halted_o.
- Hitting the limit in phase 2 still performs that round's phase 3 output.
- DRAIN: same phase behaviour as RUN, but no new round starts; after phase 3 the FSM goes to IDLE.
- Counters saturate and never wrap. placed_cnt_o keeps its value in IDLE until the next start_i.
- start_i outside IDLE is ignored. stop_i in IDLE or INIT is ignored.

## Timing
- Reset (asynchronous, rst_i=0) forces the following until the first clock edge after release:
  - state=IDLE, phase=0
  - all enables, clr_o, out_valid_o, busy_o, halted_o = 0
  - clr_addr_o=0, placed_cnt_o=0, strike_cnt_o=0
- Reset mid-round aborts immediately. No write completes after reset assertion.
- start_i sampled at edge t: INIT writes occupy cycles t+1 .. t+NUM_STRIPS; phase 0 of round 1 is cycle t+NUM_STRIPS+1.
- Enables are registered-free decodes of state/phase and are high for exactly one cycle per round.
- Latency: sample (phase 0) to out_en_o (phase 3) is 3 cycles.
- out_valid_o rises the cycle after an out_en_o pulse. It stays high until the next phase-3 edge of a round with item_v=0, or until reset.
- Throughput: one rectangle per 4 cycles. A round's write completes before the next round's read, so no forwarding is needed.

## Test plan
- Reset/INIT: rst_i low mid-INIT → all outputs 0. Release, then start_i → wr_en_o & clr_o high for 13 consecutive cycles with clr_addr_o 0..12, then the phase-0 sample_en_o.
- Steady run: in_valid_i=1 for 5 rounds, strike_flag_i=0 → 5 pulses each of sample/rd/wr/out, spaced 4 cycles apart. placed_cnt_o=5, out_valid_o high from the first round's phase 3+1.
- Bubble: in_valid_i=0 in round 2 → no rd/wr/out in round 2, placed_cnt unchanged, out_valid_o drops after round 2's phase 3.
- Strike gating: strike_flag_i=1 in phase 2 of round 3 → wr_en_o=0, strike_cnt_o increments, out_en_o still pulses.
- Halt: STRIKE_MAX=2, two strikes → after the second strike's phase 3 the FSM goes to IDLE, halted_o=1, busy_o=0. A later start_i clears halted_o and the counters.
- Stop mid-round: stop_i in phase 1 → that round completes through phase 3, then IDLE, and no further sample_en_o pulses occur.

Source files
------------

// File: rtl/placement_sequencer.sv
// Stage-enable sequencer for the rectangle-placement datapath: clears the strip
// occupancy array, then runs 4-phase sample/read/write/output rounds until stopped or halted.
//
// state | meaning
// IDLE  | waiting for start_i, all enables low, counters hold their last values
// INIT  | clearing occupancy entries 0..NUM_STRIPS-1, one per cycle
// RUN   | placement rounds, phase 0..3 repeating
// DRAIN | finishing the current round after a stop or strike limit
module placement_sequencer #(
    parameter int NUM_STRIPS = 13,
    parameter int STRIKE_MAX = 15
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       stop_i,
    input  logic       in_valid_i,
    input  logic       strike_flag_i,
    output logic       sample_en_o,
    output logic       rd_en_o,
    output logic       wr_en_o,
    output logic       clr_o,
    output logic [3:0] clr_addr_o,
    output logic       out_en_o,
    output logic       out_valid_o,
    output logic       busy_o,
    output logic       halted_o,
    output logic [7:0] placed_cnt_o,
    output logic [3:0] strike_cnt_o
);

    localparam logic [3:0] LAST_ADDR    = 4'(NUM_STRIPS - 1);
    localparam logic [3:0] STRIKE_LIMIT = 4'(STRIKE_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INIT  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t     state, state_next;
    logic [1:0] phase, phase_next;
    logic [3:0] clr_addr, clr_addr_next;
    logic       item_v, item_v_next;
    logic [7:0] placed_cnt, placed_cnt_next;
    logic [3:0] strike_cnt, strike_cnt_next;
    logic       halted, halted_next;
    logic       out_valid, out_valid_next;
    logic       limit_hit;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= IDLE;
            phase      <= 2'd0;
            clr_addr   <= 4'd0;
            item_v     <= 1'b0;
            placed_cnt <= 8'd0;
            strike_cnt <= 4'd0;
            halted     <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            state      <= state_next;
            phase      <= phase_next;
            clr_addr   <= clr_addr_next;
            item_v     <= item_v_next;
            placed_cnt <= placed_cnt_next;
            strike_cnt <= strike_cnt_next;
            halted     <= halted_next;
            out_valid  <= out_valid_next;
        end
    end

    assign limit_hit = (strike_cnt == STRIKE_LIMIT);

    always_comb begin
        state_next      = state;
        phase_next      = phase;
        clr_addr_next   = clr_addr;
        item_v_next     = item_v;
        placed_cnt_next = placed_cnt;
        strike_cnt_next = strike_cnt;
        halted_next     = halted;
        out_valid_next  = out_valid;
        sample_en_o     = 1'b0;
        rd_en_o         = 1'b0;
        wr_en_o         = 1'b0;
        clr_o           = 1'b0;
        out_en_o        = 1'b0;

        case (state)
            IDLE: begin
                phase_next = 2'd0;
                if (start_i) begin
                    state_next      = INIT;
                    clr_addr_next   = 4'd0;
                    placed_cnt_next = 8'd0;
                    strike_cnt_next = 4'd0;
                    halted_next     = 1'b0;
                end
            end

            INIT: begin
                wr_en_o = 1'b1;
                clr_o   = 1'b1;
                if (clr_addr == LAST_ADDR) begin
                    state_next    = RUN;
                    phase_next    = 2'd0;
                    clr_addr_next = 4'd0;
                end else begin
                    clr_addr_next = clr_addr + 4'd1;
                end
            end

            RUN, DRAIN: begin
                phase_next = phase + 2'd1;
                case (phase)
                    2'd0: begin
                        sample_en_o = 1'b1;
                        item_v_next = in_valid_i;
                    end
                    2'd1: rd_en_o = item_v;
                    2'd2: begin
                        // A strike suppresses the occupancy write but the round still outputs.
                        wr_en_o = item_v & ~strike_flag_i;
                        if (item_v && strike_flag_i) begin
                            if (strike_cnt < STRIKE_LIMIT)
                                strike_cnt_next = strike_cnt + 4'd1;
                            if (strike_cnt + 4'd1 == STRIKE_LIMIT)
                                halted_next = 1'b1;
                        end else if (item_v && placed_cnt != 8'hFF) begin
                            placed_cnt_next = placed_cnt + 8'd1;
                        end
                    end
                    default: begin
                        out_en_o       = item_v;
                        out_valid_next = item_v;
                    end
                endcase

                if (state == RUN) begin
                    if (stop_i || limit_hit)
                        state_next = (phase == 2'd3) ? IDLE : DRAIN;
                end else if (phase == 2'd3) begin
                    state_next = IDLE;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    assign clr_addr_o   = clr_addr;
    assign out_valid_o  = out_valid;
    assign busy_o       = (state != IDLE);
    assign halted_o     = halted;
    assign placed_cnt_o = placed_cnt;
    assign strike_cnt_o = strike_cnt;

endmodule

// File: tb/tb_placement_sequencer.sv
// Directed bench for placement_sequencer: reset, INIT clear, round table, stop and strike halt.
module tb_placement_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       in_valid = 1'b0;
    logic       strike = 1'b0;
    logic       sample_en, rd_en, wr_en, clr, out_en, out_valid, busy, halted;
    logic [3:0] clr_addr;
    logic [7:0] placed_cnt;
    logic [3:0] strike_cnt;

    always #5 clk = ~clk;

    placement_sequencer #(
        .NUM_STRIPS(13),
        .STRIKE_MAX(2)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .stop_i       (stop),
        .in_valid_i   (in_valid),
        .strike_flag_i(strike),
        .sample_en_o  (sample_en),
        .rd_en_o      (rd_en),
        .wr_en_o      (wr_en),
        .clr_o        (clr),
        .clr_addr_o   (clr_addr),
        .out_en_o     (out_en),
        .out_valid_o  (out_valid),
        .busy_o       (busy),
        .halted_o     (halted),
        .placed_cnt_o (placed_cnt),
        .strike_cnt_o (strike_cnt)
    );

    typedef struct {
        logic       v;
        logic       s;
        logic       rd;
        logic       wr;
        logic       oe;
        logic [7:0] placed;
        logic [3:0] strk;
        logic       ov;
    } round_t;

    round_t rounds[7];
    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic do_init();
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        check("start_clr_placed", 32'(placed_cnt), 0);
        check("start_clr_strike", 32'(strike_cnt), 0);
        check("start_clr_halted", 32'(halted), 0);
        for (int i = 0; i < 13; i++) begin
            settle();
            check("init_wr", 32'(wr_en), 1);
            check("init_clr", 32'(clr), 1);
            check("init_addr", 32'(clr_addr), 32'(i));
            check("init_no_sample", 32'(sample_en), 0);
            next_cycle();
        end
    endtask

    task automatic run_round(input round_t r);
        in_valid = r.v;
        settle();
        check("ph0_sample", 32'(sample_en), 1);
        check("ph0_busy", 32'(busy), 1);
        next_cycle();
        in_valid = 1'b0;
        settle();
        check("ph1_rd", 32'(rd_en), 32'(r.rd));
        check("ph1_no_sample", 32'(sample_en), 0);
        next_cycle();
        strike = r.s;
        settle();
        check("ph2_wr", 32'(wr_en), 32'(r.wr));
        next_cycle();
        strike = 1'b0;
        settle();
        check("ph3_out_en", 32'(out_en), 32'(r.oe));
        check("ph3_placed", 32'(placed_cnt), 32'(r.placed));
        check("ph3_strike", 32'(strike_cnt), 32'(r.strk));
        next_cycle();
        check("out_valid", 32'(out_valid), 32'(r.ov));
    endtask

    initial begin
        int samples;
        //            v  s  rd wr oe placed strk ov
        rounds[0] = '{1, 0, 1, 1, 1, 8'd1, 4'd0, 1};
        rounds[1] = '{1, 0, 1, 1, 1, 8'd2, 4'd0, 1};
        rounds[2] = '{0, 0, 0, 0, 0, 8'd2, 4'd0, 0};
        rounds[3] = '{1, 1, 1, 0, 1, 8'd2, 4'd1, 1};
        rounds[4] = '{1, 0, 1, 1, 1, 8'd3, 4'd1, 1};
        rounds[5] = '{1, 0, 1, 1, 1, 8'd4, 4'd1, 1};
        rounds[6] = '{1, 0, 1, 1, 1, 8'd5, 4'd1, 1};

        #1 rst = 1'b0;
        #2;
        check("rst_busy", 32'(busy), 0);
        check("rst_wr", 32'(wr_en), 0);
        check("rst_clr", 32'(clr), 0);
        check("rst_addr", 32'(clr_addr), 0);
        check("rst_placed", 32'(placed_cnt), 0);
        check("rst_strike", 32'(strike_cnt), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        @(posedge clk);
        #1 rst = 1'b1;
        next_cycle();

        // Reset in the middle of INIT must drop all outputs immediately.
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        repeat (4) next_cycle();
        settle();
        check("midinit_addr", 32'(clr_addr), 4);
        check("midinit_wr", 32'(wr_en), 1);
        rst = 1'b0;
        #1;
        check("midrst_wr", 32'(wr_en), 0);
        check("midrst_clr", 32'(clr), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_addr", 32'(clr_addr), 0);
        next_cycle();
        rst = 1'b1;
        next_cycle();

        stop = 1'b1;
        next_cycle();
        stop = 1'b0;
        check("idle_stop_ignored", 32'(busy), 0);

        do_init();
        for (int i = 0; i < 7; i++) run_round(rounds[i]);

        // Stop in phase 1: round completes, then IDLE with no further sampling.
        in_valid = 1'b1;
        settle();
        check("stop_ph0_sample", 32'(sample_en), 1);
        next_cycle();
        in_valid = 1'b0;
        stop = 1'b1;
        settle();
        check("stop_ph1_rd", 32'(rd_en), 1);
        next_cycle();
        stop = 1'b0;
        settle();
        check("stop_ph2_wr", 32'(wr_en), 1);
        check("stop_ph2_busy", 32'(busy), 1);
        next_cycle();
        settle();
        check("stop_ph3_out_en", 32'(out_en), 1);
        next_cycle();
        settle();
        check("stop_idle_busy", 32'(busy), 0);
        check("stop_placed", 32'(placed_cnt), 6);
        samples = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            next_cycle();
            if (sample_en) samples++;
        end
        in_valid = 1'b0;
        check("stop_no_sample", samples, 0);
        check("idle_placed_held", 32'(placed_cnt), 6);

        // Two strikes with STRIKE_MAX=2 halt after the second round's output.
        do_init();
        run_round('{1, 1, 1, 0, 1, 8'd0, 4'd1, 1});
        check("halt_not_yet", 32'(halted), 0);
        run_round('{1, 1, 1, 0, 1, 8'd0, 4'd2, 1});
        settle();
        check("halt_busy", 32'(busy), 0);
        check("halt_flag", 32'(halted), 1);
        check("halt_no_sample", 32'(sample_en), 0);
        next_cycle();
        check("halt_sticky", 32'(halted), 1);

        start = 1'b1;
        next_cycle();
        start = 1'b0;
        check("restart_halted", 32'(halted), 0);
        check("restart_strike", 32'(strike_cnt), 0);
        check("restart_placed", 32'(placed_cnt), 0);
        check("restart_busy", 32'(busy), 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
